// File: rtl/text_console_writer.sv
// text_console_writer
//
// Turns a stream of 7-bit ASCII characters into writes on a tile-based
// screen buffer (H_TILES x V_TILES tiles, one byte per tile). The buffer
// write port is word-wide: each write carries C_AXI_DATA_WIDTH/8 byte
// lanes, and strobe bit k writes tile w_addr_o+k.
//
// Printable characters are written at the cursor and advance it. LF, CR,
// BS and FF move the cursor. Entering a new line blanks that line with
// word writes. FF or clear_i blanks the whole screen.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   char_valid_i      character available
//   char_i[6:0]       ASCII code
//   char_ready_o      character accepted when char_valid_i && char_ready_o
//   clear_i           clear-screen request, only acted on while idle
//   busy_o            high while a line or screen clear is in progress
//   wr_en_o           screen-buffer write enable (registered)
//   w_addr_o          tile address of byte lane 0 (registered)
//   w_strb_o          byte-lane strobe (registered)
//   din_o             write data, lane k bits [6:0] = tile code (registered)
//   cursor_col_o      cursor column
//   cursor_row_o      cursor row
module text_console_writer #(
    parameter int H_TILES          = 80,
    parameter int V_TILES          = 30,
    parameter int NUM_TILES        = H_TILES * V_TILES,
    parameter int C_AXI_ADDR_WIDTH = $clog2(NUM_TILES),
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          char_valid_i,
    input  logic [6:0]                    char_i,
    output logic                          char_ready_o,
    input  logic                          clear_i,
    output logic                          busy_o,
    output logic                          wr_en_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   w_addr_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic [C_AXI_DATA_WIDTH-1:0]   din_o,
    output logic [6:0]                    cursor_col_o,
    output logic [4:0]                    cursor_row_o
);

    localparam int AW           = C_AXI_ADDR_WIDTH;
    localparam int STRB_W       = C_AXI_DATA_WIDTH / 8;
    localparam int LINE_WORDS   = H_TILES / STRB_W;
    localparam int SCREEN_WORDS = NUM_TILES / STRB_W;
    localparam int CNT_W        = $clog2(SCREEN_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_SCREEN
    } state_t;

    state_t                        state_reg;
    logic [6:0]                    col_reg;
    logic [4:0]                    row_reg;
    logic [AW-1:0]                 clr_addr_reg;
    logic [CNT_W-1:0]              clr_cnt_reg;
    logic                          wr_en_reg;
    logic [AW-1:0]                 w_addr_reg;
    logic [STRB_W-1:0]             w_strb_reg;
    logic [C_AXI_DATA_WIDTH-1:0]   din_reg;

    logic [4:0]                    next_row;
    logic [AW-1:0]                 cur_addr;

    function automatic logic [AW-1:0] tile_addr(input logic [4:0] r, input logic [6:0] c);
        return AW'(r) * AW'(H_TILES) + AW'(c);
    endfunction

    // clear_i wins over a simultaneous character by withholding ready.
    assign char_ready_o = (state_reg == IDLE) && !clear_i;
    assign busy_o       = (state_reg != IDLE);
    assign wr_en_o      = wr_en_reg;
    assign w_addr_o     = w_addr_reg;
    assign w_strb_o     = w_strb_reg;
    assign din_o        = din_reg;
    assign cursor_col_o = col_reg;
    assign cursor_row_o = row_reg;

    assign next_row = (row_reg == 5'(V_TILES - 1)) ? 5'd0 : row_reg + 5'd1;
    assign cur_addr = tile_addr(row_reg, col_reg);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            col_reg      <= '0;
            row_reg      <= '0;
            clr_addr_reg <= '0;
            clr_cnt_reg  <= '0;
            wr_en_reg    <= 1'b0;
            w_addr_reg   <= '0;
            w_strb_reg   <= '0;
            din_reg      <= '0;
        end else begin
            wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clear_i || (char_valid_i && char_i == 7'h0C)) begin
                        col_reg      <= '0;
                        row_reg      <= '0;
                        clr_addr_reg <= '0;
                        clr_cnt_reg  <= CNT_W'(SCREEN_WORDS - 1);
                        state_reg    <= CLR_SCREEN;
                    end else if (char_valid_i) begin
                        if (char_i >= 7'h20) begin
                            wr_en_reg  <= 1'b1;
                            w_addr_reg <= cur_addr;
                            w_strb_reg <= STRB_W'(1);
                            din_reg    <= C_AXI_DATA_WIDTH'(char_i);
                            if (col_reg == 7'(H_TILES - 1)) begin
                                // Line wrap: blank the line we land on.
                                col_reg      <= '0;
                                row_reg      <= next_row;
                                clr_addr_reg <= tile_addr(next_row, 7'd0);
                                clr_cnt_reg  <= CNT_W'(LINE_WORDS - 1);
                                state_reg    <= CLR_LINE;
                            end else begin
                                col_reg <= col_reg + 7'd1;
                            end
                        end else begin
                            case (char_i)
                                7'h0A: begin
                                    col_reg      <= '0;
                                    row_reg      <= next_row;
                                    clr_addr_reg <= tile_addr(next_row, 7'd0);
                                    clr_cnt_reg  <= CNT_W'(LINE_WORDS - 1);
                                    state_reg    <= CLR_LINE;
                                end
                                7'h0D: col_reg <= '0;
                                7'h08: begin
                                    if (col_reg != 7'd0) begin
                                        col_reg    <= col_reg - 7'd1;
                                        wr_en_reg  <= 1'b1;
                                        w_addr_reg <= cur_addr - AW'(1);
                                        w_strb_reg <= STRB_W'(1);
                                        din_reg    <= '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLR_LINE, CLR_SCREEN: begin
                    // One zero word per cycle; the last one leaves for IDLE.
                    wr_en_reg    <= 1'b1;
                    w_addr_reg   <= clr_addr_reg;
                    w_strb_reg   <= '1;
                    din_reg      <= '0;
                    clr_addr_reg <= clr_addr_reg + AW'(STRB_W);
                    if (clr_cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        char_valid_i = 1'b0;
    logic [6:0]  char_i = '0;
    logic        char_ready_o;
    logic        clear_i = 1'b0;
    logic        busy_o;
    logic        wr_en_o;
    logic [11:0] w_addr_o;
    logic [3:0]  w_strb_o;
    logic [31:0] din_o;
    logic [6:0]  cursor_col_o;
    logic [4:0]  cursor_row_o;

    always #20 clk = ~clk;

    text_console_writer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .char_valid_i (char_valid_i),
        .char_i       (char_i),
        .char_ready_o (char_ready_o),
        .clear_i      (clear_i),
        .busy_o       (busy_o),
        .wr_en_o      (wr_en_o),
        .w_addr_o     (w_addr_o),
        .w_strb_o     (w_strb_o),
        .din_o        (din_o),
        .cursor_col_o (cursor_col_o),
        .cursor_row_o (cursor_row_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cursor plus a queue of pending clear-word addresses.
    // The writer is idle exactly when no clear words are pending.
    int m_row = 0;
    int m_col = 0;
    int clr_q[$];
    bit e_wr = 0;
    int e_addr = 0;
    int e_strb = 0;
    int e_din = 0;
    bit e_all = 1;

    // Observation statistics for directed checks.
    int wr_count = 0;
    int first_addr = -1;
    int last_addr = -1;
    int prev_addr = -1;
    int busy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic stats_clear();
        wr_count = 0; first_addr = -1; last_addr = -1; prev_addr = -1; busy_cycles = 0;
    endtask

    task automatic model_newline();
        m_col = 0;
        m_row = (m_row + 1) % 30;
        for (int i = 0; i < 20; i++) clr_q.push_back(m_row * 80 + 4 * i);
    endtask

    task automatic model_clear_screen();
        m_col = 0;
        m_row = 0;
        for (int i = 0; i < 600; i++) clr_q.push_back(4 * i);
    endtask

    // One clock cycle: drive inputs, check ready, model the edge, compare outputs.
    task automatic step(input bit v, input logic [6:0] c, input bit clr, input bit r, output bit acc);
        bit idle;
        char_valid_i = v; char_i = c; clear_i = clr; rst_i = r;
        #1;
        idle = (clr_q.size() == 0);
        acc  = !r && v && idle && !clr;
        if (!r) check("char_ready", 32'(char_ready_o), 32'(idle && !clr));
        @(posedge clk);
        e_wr = 0;
        e_all = r;
        if (r) begin
            m_row = 0; m_col = 0; clr_q.delete();
            e_addr = 0; e_strb = 0; e_din = 0;
        end else if (!idle) begin
            e_wr = 1; e_addr = clr_q.pop_front(); e_strb = 4'hF; e_din = 0;
        end else if (clr || (v && c == 7'h0C)) begin
            model_clear_screen();
        end else if (v) begin
            if (c >= 7'h20) begin
                e_wr = 1; e_addr = m_row * 80 + m_col; e_strb = 1; e_din = int'(c);
                m_col++;
                if (m_col == 80) model_newline();
            end else if (c == 7'h0A) begin
                model_newline();
            end else if (c == 7'h0D) begin
                m_col = 0;
            end else if (c == 7'h08 && m_col > 0) begin
                m_col--;
                e_wr = 1; e_addr = m_row * 80 + m_col; e_strb = 1; e_din = 0;
            end
        end
        if (acc) $display("txn char=%02h -> cursor (%0d,%0d)", c, m_row, m_col);
        else if (!r && idle && clr) $display("txn clear_screen");
        @(negedge clk);
        check("wr_en", 32'(wr_en_o), 32'(e_wr));
        if (e_wr || e_all) begin
            check("w_addr", 32'(w_addr_o), 32'(e_addr));
            check("w_strb", 32'(w_strb_o), 32'(e_strb));
            check("din", din_o, 32'(e_din));
        end
        check("cursor_row", 32'(cursor_row_o), 32'(m_row));
        check("cursor_col", 32'(cursor_col_o), 32'(m_col));
        check("busy", 32'(busy_o), 32'(clr_q.size() != 0));
        if (wr_en_o) begin
            wr_count++;
            if (first_addr < 0) first_addr = int'(w_addr_o);
            prev_addr = last_addr;
            last_addr = int'(w_addr_o);
        end
        if (busy_o) busy_cycles++;
    endtask

    task automatic send_char(input logic [6:0] c);
        bit acc;
        int n;
        acc = 0; n = 0;
        while (!acc && n < 2000) begin
            step(1, c, 0, 0, acc);
            n++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_char timeout: char %02h not accepted within %0d cycles", c, n);
        end
    endtask

    task automatic wait_idle();
        bit acc;
        int n;
        n = 0;
        while (clr_q.size() != 0 && n < 2000) begin
            step(0, 7'h00, 0, 0, acc);
            n++;
        end
        check("wait_idle_bounded", 32'(clr_q.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        // Reset state
        step(0, 7'h00, 0, 1, acc);
        step(0, 7'h00, 0, 1, acc);
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_addr", 32'(w_addr_o), 32'd0);
        check("rst_strb", 32'(w_strb_o), 32'd0);
        check("rst_din", din_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        // First printable character
        send_char(7'h41);
        check("a_wr", 32'(wr_en_o), 32'd1);
        check("a_addr", 32'(w_addr_o), 32'd0);
        check("a_strb", 32'(w_strb_o), 32'd1);
        check("a_din", din_o, 32'h41);
        check("a_col", 32'(cursor_col_o), 32'd1);

        // Wrap at column 79
        for (int i = 0; i < 78; i++) send_char(7'h61);
        check("pre_wrap_col", 32'(cursor_col_o), 32'd79);
        stats_clear();
        send_char(7'h42);
        check("wrap_addr", 32'(w_addr_o), 32'd79);
        wait_idle();
        check("wrap_writes", 32'(wr_count), 32'd21);
        check("wrap_busy", 32'(busy_cycles), 32'd20);
        check("wrap_last", 32'(last_addr), 32'd156);
        check("wrap_row", 32'(cursor_row_o), 32'd1);
        check("wrap_col", 32'(cursor_col_o), 32'd0);

        // LF from row 29 wraps to row 0
        for (int i = 0; i < 28; i++) send_char(7'h0A);
        wait_idle();
        for (int i = 0; i < 5; i++) send_char(7'h7E);
        check("lf_pre_row", 32'(cursor_row_o), 32'd29);
        stats_clear();
        send_char(7'h0A);
        wait_idle();
        check("lf_writes", 32'(wr_count), 32'd20);
        check("lf_first", 32'(first_addr), 32'd0);
        check("lf_last", 32'(last_addr), 32'd76);
        check("lf_row", 32'(cursor_row_o), 32'd0);

        // Backspace
        for (int i = 0; i < 3; i++) send_char(7'h0A);
        wait_idle();
        for (int i = 0; i < 10; i++) send_char(7'h30);
        send_char(7'h08);
        check("bs_wr", 32'(wr_en_o), 32'd1);
        check("bs_addr", 32'(w_addr_o), 32'd249);
        check("bs_din", din_o, 32'd0);
        check("bs_col", 32'(cursor_col_o), 32'd9);
        send_char(7'h0D);
        send_char(7'h08);
        check("bs0_wr", 32'(wr_en_o), 32'd0);
        check("bs0_col", 32'(cursor_col_o), 32'd0);
        check("bs0_row", 32'(cursor_row_o), 32'd3);

        // clear_i beats a simultaneous character
        stats_clear();
        step(1, 7'h43, 1, 0, acc);
        check("clr_not_acc", 32'(acc), 32'd0);
        send_char(7'h43);
        check("clr_writes", 32'(wr_count), 32'd601);
        check("clr_busy", 32'(busy_cycles), 32'd600);
        check("clr_last_clear", 32'(prev_addr), 32'd2396);
        check("clr_char_addr", 32'(w_addr_o), 32'd0);
        check("clr_char_din", din_o, 32'h43);

        // Reset in the middle of a screen clear
        stats_clear();
        send_char(7'h0C);
        while (wr_count < 100 && total < 1000000) step(0, 7'h00, 0, 0, acc);
        step(0, 7'h00, 0, 1, acc);
        check("rst_mid_wr", 32'(wr_en_o), 32'd0);
        check("rst_mid_row", 32'(cursor_row_o), 32'd0);
        check("rst_mid_col", 32'(cursor_col_o), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 7'h00, 0, 0, acc);
        check("rst_mid_count", 32'(wr_count), 32'd100);
        check("rst_mid_ready", 32'(char_ready_o), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, clr, v;
            int k;
            logic [6:0] c;
            r   = ($urandom_range(0, 999) == 0);
            clr = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 3) != 0);
            k   = $urandom_range(0, 15);
            case (k)
                0: c = 7'h0A;
                1: c = 7'h0D;
                2, 3: c = 7'h08;
                4: c = 7'($urandom_range(0, 31));
                default: c = 7'($urandom_range(32, 127));
            endcase
            step(v, c, clr, r, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
